// File: rtl/fsm_alu_seq.sv
// fsm_alu_seq: handshake/confirm ALU controller with operand capture, accumulate mode, flags, cancel and timeout.
//   clk, reset (async, active-low)     : clock and reset
//   handshaking, operand_a/b           : operand capture request and operands (IDLE only)
//   confirm_op, cancel_op              : execute / abort requests (WAIT_CONFIRM only)
//   acc_mode, switch_op                : accumulate select and opcode, latched with confirm_op
//   alu_result, flag_z/n/c/v           : registered result and status flags
//   busy, done, timeout                : not-idle status, result strobe, abort-on-timeout strobe
module fsm_alu_seq #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             handshaking,
    input  logic             confirm_op,
    input  logic             cancel_op,
    input  logic             acc_mode,
    input  logic [2:0]       switch_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done,
    output logic             timeout
);
    localparam int MSB = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_EXEC = 2'b10} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, w_a, w_res;
    logic [2:0]       r_op;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cap, w_lat, w_inc, w_to, w_c, w_v;
    logic [WIDTH:0]   w_sum, w_dif;
    assign busy = (r_state != S_IDLE);
    always_comb begin
        w_next = S_IDLE;
        w_cap  = 1'b0;
        w_lat  = 1'b0;
        w_inc  = 1'b0;
        w_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = handshaking ? S_WAIT : S_IDLE;
                w_cap  = handshaking;
            end
            S_WAIT: begin
                if (cancel_op) w_next = S_IDLE;
                else if (confirm_op) begin
                    w_next = S_EXEC;
                    w_lat  = 1'b1;
                end else if (TIMEOUT != 0 && r_cnt == LAST) w_to = 1'b1;
                else begin
                    w_next = S_WAIT;
                    w_inc  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
    // Accumulate mode chains the previous result in as operand A.
    assign w_a   = r_acc ? alu_result : r_a;
    assign w_sum = {1'b0, w_a} + {1'b0, r_b};
    assign w_dif = {1'b0, w_a} - {1'b0, r_b};
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            3'b000: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[MSB] == r_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
            3'b001: begin
                w_res = w_dif[MSB:0];
                w_c   = w_dif[WIDTH];
                w_v   = (w_a[MSB] != r_b[MSB]) && (w_dif[MSB] != w_a[MSB]);
            end
            3'b010: w_res = w_a & r_b;
            3'b011: w_res = w_a | r_b;
            3'b100: w_res = w_a ^ r_b;
            3'b101: begin
                w_res = {w_a[MSB-1:0], 1'b0};
                w_c   = w_a[MSB];
            end
            3'b110: begin
                w_res = {1'b0, w_a[MSB:1]};
                w_c   = w_a[0];
            end
            default: w_res = r_b;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            alu_result <= '0;
            {flag_z, flag_n, flag_c, flag_v} <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= 1'b0;
            timeout <= w_to;
            if (w_cap) begin
                r_a   <= operand_a;
                r_b   <= operand_b;
                r_cnt <= '0;
            end
            if (w_inc) r_cnt <= r_cnt + 1'b1;
            if (w_lat) begin
                r_op  <= switch_op;
                r_acc <= acc_mode;
            end
            if (r_state == S_EXEC) begin
                alu_result <= w_res;
                flag_z     <= (w_res == '0);
                flag_n     <= w_res[MSB];
                flag_c     <= w_c;
                flag_v     <= w_v;
                done       <= 1'b1;
            end
        end
    end
endmodule
